// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join controller and its helpers.
//   fj_mode_e      : join policy selected per operation
//   fj_state_e     : controller state encoding
//   FJ_MAX_CH      : upper bound on the channel count
//   fj_decode_mode : maps the raw 2-bit mode field onto fj_mode_e
package fork_join_pkg;

   localparam int FJ_MAX_CH = 32;

   typedef enum logic [1:0] {
      JOIN_ALL  = 2'd0,
      JOIN_ANY  = 2'd1,
      JOIN_NONE = 2'd2
   } fj_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_KILL   = 3'd3,
      ST_DONE   = 3'd4
   } fj_state_e;

   // Code 3 is reserved and behaves as JOIN_ALL.
   function automatic fj_mode_e fj_decode_mode(input logic [1:0] m);
      case (m)
         2'd1:    return JOIN_ANY;
         2'd2:    return JOIN_NONE;
         default: return JOIN_ALL;
      endcase
   endfunction

endpackage

// File: rtl/fj_timeout_cnt.sv
// Loadable up-counter with a compare against a limit, for watchdog use.
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : load load_val_i (has priority over en_i)
//   load_val_i  : value loaded
//   en_i        : count up by one; saturates at all-ones so it never wraps
//   limit_i     : compare value
//   reached_o   : the value the counter takes at the next edge equals limit_i,
//                 so the caller can act on the post-update count in the same cycle
module fj_timeout_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   input  logic [W-1:0] limit_i,
   output logic         reached_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   assign reached_o = (cnt_d == limit_i);

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join controller: launches a set of job channels with one start request
// and waits for them according to the join mode, killing leftovers on early
// join, abort or timeout.
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : start request (IDLE only)
//   mode_i       : join mode, latched on start
//   ch_mask_i    : channels to launch, latched on start
//   timeout_i    : max WAIT cycles, 0 = none, latched on start
//   abort_i      : kill pending channels (WAIT only)
//   ch_done_i    : per-channel completion pulses
//   ch_start_o   : launch pulses
//   ch_kill_o    : kill pulses
//   busy_o       : not IDLE
//   done_o       : completion pulse
//   finished_o   : channels that completed
//   killed_o     : channels that were killed
//   timeout_o    : last operation ended by timeout
//
// state  | meaning
// IDLE   | waiting for start_i
// LAUNCH | one cycle, pulse ch_start_o for the latched mask
// WAIT   | collect ch_done_i, evaluate join / abort / timeout
// KILL   | one cycle, pulse ch_kill_o for still-pending channels
// DONE   | one cycle, pulse done_o
module fork_join_ctrl
   import fork_join_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int TMO_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       mode_i,
   input  logic [N_CH-1:0]  ch_mask_i,
   input  logic [TMO_W-1:0] timeout_i,
   input  logic             abort_i,
   input  logic [N_CH-1:0]  ch_done_i,
   output logic [N_CH-1:0]  ch_start_o,
   output logic [N_CH-1:0]  ch_kill_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [N_CH-1:0]  finished_o,
   output logic [N_CH-1:0]  killed_o,
   output logic             timeout_o
);

   if (N_CH < 1 || N_CH > FJ_MAX_CH) begin : g_bad_n_ch
      $error("fork_join_ctrl: N_CH out of range");
   end

   fj_state_e        state_q, state_d;
   fj_mode_e         mode_q, mode_d;
   logic [N_CH-1:0]  mask_q, mask_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [N_CH-1:0]  fin_q, fin_d;
   logic [N_CH-1:0]  kil_q, kil_d;
   logic             tflag_q, tflag_d;

   logic [N_CH-1:0]  pend;
   logic [N_CH-1:0]  fin_post;
   logic [N_CH-1:0]  pend_post;
   logic             tmr_load, tmr_en, tmr_reached;

   assign pend      = mask_q & ~fin_q;
   // Done pulses outside the pending set are ignored.
   assign fin_post  = fin_q | (ch_done_i & pend);
   assign pend_post = mask_q & ~fin_post;

   fj_timeout_cnt #(.W(TMO_W)) u_tmr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i ('0),
      .en_i       (tmr_en),
      .limit_i    (tmo_q),
      .reached_o  (tmr_reached)
   );

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      mask_d   = mask_q;
      tmo_d    = tmo_q;
      fin_d    = fin_q;
      kil_d    = kil_q;
      tflag_d  = tflag_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               // Status is cleared on acceptance so it already reads 0 in LAUNCH.
               fin_d   = '0;
               kil_d   = '0;
               tflag_d = 1'b0;
               mask_d  = ch_mask_i;
               mode_d  = fj_decode_mode(mode_i);
               tmo_d   = timeout_i;
               state_d = (ch_mask_i != '0) ? ST_LAUNCH : ST_DONE;
            end
         end
         ST_LAUNCH: begin
            tmr_load = 1'b1;
            state_d  = (mode_q == JOIN_NONE) ? ST_DONE : ST_WAIT;
         end
         ST_WAIT: begin
            tmr_en = 1'b1;
            fin_d  = fin_post;
            if (mode_q == JOIN_ALL && pend_post == '0)
               state_d = ST_DONE;
            else if (mode_q == JOIN_ANY && fin_post != '0)
               state_d = (pend_post != '0) ? ST_KILL : ST_DONE;
            else if (abort_i)
               state_d = ST_KILL;
            else if (tmo_q != '0 && tmr_reached) begin
               state_d = ST_KILL;
               tflag_d = 1'b1;
            end
         end
         ST_KILL: begin
            kil_d   = kil_q | pend;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode_q  <= JOIN_ALL;
         mask_q  <= '0;
         tmo_q   <= '0;
         fin_q   <= '0;
         kil_q   <= '0;
         tflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         mask_q  <= mask_d;
         tmo_q   <= tmo_d;
         fin_q   <= fin_d;
         kil_q   <= kil_d;
         tflag_q <= tflag_d;
      end
   end

   // Pulses are gated by rst so a reset landing on LAUNCH/KILL/DONE emits nothing.
   assign ch_start_o = (state_q == ST_LAUNCH && !rst) ? mask_q : '0;
   assign ch_kill_o  = (state_q == ST_KILL   && !rst) ? pend   : '0;
   assign done_o     = (state_q == ST_DONE)   && !rst;
   assign busy_o     = (state_q != ST_IDLE);
   assign finished_o = fin_q;
   assign killed_o   = kil_q;
   assign timeout_o  = tflag_q;

endmodule

// File: tb/tb_fork_join_ctrl.sv
module tb_fork_join_ctrl;
   import fork_join_pkg::*;

   localparam int N    = 4;
   localparam int TW   = 16;
   localparam int MAXK = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [1:0]    mode_i;
   logic [N-1:0]  ch_mask_i;
   logic [TW-1:0] timeout_i;
   logic          abort_i;
   logic [N-1:0]  ch_done_i;
   logic [N-1:0]  ch_start_o, ch_kill_o, finished_o, killed_o;
   logic          busy_o, done_o, timeout_o;

   int cmp_cnt = 0;
   int err_cnt = 0;

   // Done pulses indexed by WAIT cycle number (1 = first WAIT cycle).
   logic [N-1:0] sched [0:MAXK];

   always #5 clk = ~clk;

   fork_join_ctrl #(.N_CH(N), .TMO_W(TW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .mode_i     (mode_i),
      .ch_mask_i  (ch_mask_i),
      .timeout_i  (timeout_i),
      .abort_i    (abort_i),
      .ch_done_i  (ch_done_i),
      .ch_start_o (ch_start_o),
      .ch_kill_o  (ch_kill_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .finished_o (finished_o),
      .killed_o   (killed_o),
      .timeout_o  (timeout_o)
   );

   task automatic clr_sched();
      for (int k = 0; k <= MAXK; k++) sched[k] = '0;
   endtask

   // Reference: walk WAIT cycles applying the join rules; cycle numbers are
   // counted from the accepting edge (LAUNCH = cycle 1).
   task automatic model(input logic [N-1:0] mask, input logic [1:0] mode,
                        input logic [TW-1:0] tmo, input int abort_k,
                        output logic [N-1:0] e_fin, output logic [N-1:0] e_kill,
                        output logic e_tf, output int e_done);
      logic [N-1:0] pend;
      int m;
      e_fin = '0; e_kill = '0; e_tf = 1'b0; e_done = -1;
      m = (mode == 2'd3) ? 0 : int'(mode);
      if (mask == '0) begin
         e_done = 1;
         return;
      end
      if (m == 2) begin
         e_done = 2;
         return;
      end
      for (int k = 1; k <= MAXK; k++) begin
         e_fin = e_fin | (sched[k] & mask);
         pend  = mask & ~e_fin;
         if (m == 0 && pend == '0) begin
            e_done = k + 2; return;
         end
         if (m == 1 && e_fin != '0) begin
            e_kill = pend;
            e_done = (pend != '0) ? k + 3 : k + 2;
            return;
         end
         if (k == abort_k) begin
            e_kill = pend; e_done = k + 3; return;
         end
         if (tmo != '0 && k == int'(tmo)) begin
            e_kill = pend; e_tf = 1'b1; e_done = k + 3; return;
         end
      end
   endtask

   task automatic run_txn(input string name, input logic [N-1:0] mask, input logic [1:0] mode,
                          input logic [TW-1:0] tmo, input int abort_k, input bit hold_start);
      logic [N-1:0] e_fin, e_kill, start_val, kill_val, o_fin, o_kil;
      logic         e_tf, o_tf;
      int           e_done, c, done_cyc, start_cyc, kill_cyc, n_start, n_kill;
      bit           got_done;
      model(mask, mode, tmo, abort_k, e_fin, e_kill, e_tf, e_done);
      n_start = 0; n_kill = 0; start_cyc = -1; kill_cyc = -1; done_cyc = -1;
      start_val = '0; kill_val = '0; o_fin = '0; o_kil = '0; o_tf = 1'b0;
      got_done = 0;

      @(negedge clk);
      start_i = 1'b1; ch_mask_i = mask; mode_i = mode; timeout_i = tmo;
      abort_i = 1'b0; ch_done_i = '0;
      @(negedge clk);
      c = 1;
      while (!got_done && c <= MAXK + 8) begin
         if (ch_start_o !== '0) begin
            n_start++; start_cyc = c; start_val = ch_start_o;
         end
         if (ch_kill_o !== '0) begin
            n_kill++; kill_cyc = c; kill_val = ch_kill_o;
         end
         if (c == 1) begin
            cmp_cnt++;
            if (busy_o !== 1'b1) begin
               err_cnt++; $display("FAIL %s busy_cycle1: got %b want 1", name, busy_o);
            end
         end
         if (done_o === 1'b1) begin
            got_done = 1; done_cyc = c;
            o_fin = finished_o; o_kil = killed_o; o_tf = timeout_o;
         end
         // Drive inputs for this cycle; while busy, a conflicting start is offered.
         start_i   = hold_start && !got_done;
         ch_mask_i = ~mask;
         mode_i    = 2'd2;
         ch_done_i = (c >= 2 && c - 1 <= MAXK) ? sched[c-1] : '0;
         abort_i   = (abort_k > 0 && c - 1 == abort_k);
         if (!got_done) begin
            @(negedge clk);
            c++;
         end
      end

      cmp_cnt++;
      if (done_cyc != e_done) begin
         err_cnt++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, e_done);
      end
      cmp_cnt++;
      if (mask != '0) begin
         if (n_start != 1 || start_cyc != 1 || start_val !== mask) begin
            err_cnt++;
            $display("FAIL %s ch_start: got %b x%0d at cyc %0d want %b x1 at cyc 1",
                     name, start_val, n_start, start_cyc, mask);
         end
      end else if (n_start != 0) begin
         err_cnt++; $display("FAIL %s ch_start: got %0d pulses want 0", name, n_start);
      end
      cmp_cnt++;
      if (e_kill != '0) begin
         if (n_kill != 1 || kill_cyc != e_done - 1 || kill_val !== e_kill) begin
            err_cnt++;
            $display("FAIL %s ch_kill: got %b x%0d at cyc %0d want %b x1 at cyc %0d",
                     name, kill_val, n_kill, kill_cyc, e_kill, e_done - 1);
         end
      end else if (n_kill != 0) begin
         err_cnt++; $display("FAIL %s ch_kill: got %b x%0d want none", name, kill_val, n_kill);
      end
      cmp_cnt++;
      if (o_fin !== e_fin || o_kil !== e_kill || o_tf !== e_tf) begin
         err_cnt++;
         $display("FAIL %s status: got fin=%b kil=%b tmo=%b want fin=%b kil=%b tmo=%b",
                  name, o_fin, o_kil, o_tf, e_fin, e_kill, e_tf);
      end

      // Idle cycles with stray done/abort: status must hold, no pulses, not busy.
      start_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ch_done_i = N'($urandom);
         abort_i   = 1'($urandom);
         @(negedge clk);
         cmp_cnt++;
         if (finished_o !== e_fin || killed_o !== e_kill || timeout_o !== e_tf ||
             busy_o !== 1'b0 || ch_start_o !== '0 || ch_kill_o !== '0 || done_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s hold: got fin=%b kil=%b tmo=%b busy=%b st=%b k=%b d=%b want fin=%b kil=%b tmo=%b idle",
                     name, finished_o, killed_o, timeout_o, busy_o, ch_start_o, ch_kill_o, done_o,
                     e_fin, e_kill, e_tf);
         end
      end
      ch_done_i = '0; abort_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_i = 1'b0; mode_i = 2'd0; ch_mask_i = '0; timeout_i = '0;
      abort_i = 1'b0; ch_done_i = '0;
      repeat (3) @(negedge clk);
      cmp_cnt++;
      if (ch_start_o !== '0 || ch_kill_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
          finished_o !== '0 || killed_o !== '0 || timeout_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_state: got st=%b k=%b b=%b d=%b f=%b kl=%b t=%b want all 0",
                  ch_start_o, ch_kill_o, busy_o, done_o, finished_o, killed_o, timeout_o);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      clr_sched(); sched[5] = 4'b0001;
      run_txn("case1_any", 4'b0011, 2'd1, 16'd0, 0, 0);
      clr_sched(); sched[3] = 4'b0001; sched[6] = 4'b0001; sched[8] = 4'b0110;
      run_txn("case2_all", 4'b0111, 2'd0, 16'd0, 0, 0);
      clr_sched(); sched[1] = 4'b1111; sched[2] = 4'b0101;
      run_txn("case3_none", 4'b1111, 2'd2, 16'd0, 0, 0);
      clr_sched(); sched[2] = 4'b0001;
      run_txn("case4_timeout", 4'b1111, 2'd0, 16'd10, 0, 0);
      clr_sched(); sched[2] = 4'b0001; sched[10] = 4'b0010;
      run_txn("case5_simul", 4'b1111, 2'd0, 16'd10, 0, 0);
      clr_sched(); sched[2] = 4'b1000;
      run_txn("case6_abort", 4'b1011, 2'd0, 16'd0, 4, 0);
      clr_sched(); sched[3] = 4'b0100; sched[4] = 4'b0001;
      run_txn("case6_busy_start", 4'b0101, 2'd0, 16'd0, 0, 1);
      clr_sched();
      run_txn("case6_zero_mask", 4'b0000, 2'd0, 16'd5, 0, 0);
      clr_sched(); sched[7] = 4'b0110;
      run_txn("reserved_mode", 4'b0110, 2'd3, 16'd0, 0, 0);
   endtask

   task automatic test_reset_mid_wait();
      int n_kill;
      n_kill = 0;
      @(negedge clk);
      start_i = 1'b1; ch_mask_i = 4'b1111; mode_i = 2'd0; timeout_i = '0;
      @(negedge clk);
      start_i = 1'b0; ch_done_i = '0;
      @(negedge clk);
      ch_done_i = 4'b0001;
      @(negedge clk);
      ch_done_i = '0;
      @(negedge clk);
      cmp_cnt++;
      if (finished_o !== 4'b0001 || busy_o !== 1'b1) begin
         err_cnt++;
         $display("FAIL rst_mid_wait_pre: got fin=%b busy=%b want 0001 1", finished_o, busy_o);
      end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (ch_kill_o !== '0) n_kill++;
      end
      cmp_cnt++;
      if (ch_start_o !== '0 || ch_kill_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
          finished_o !== '0 || killed_o !== '0 || timeout_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL rst_mid_wait_outputs: got st=%b k=%b b=%b d=%b f=%b kl=%b t=%b want all 0",
                  ch_start_o, ch_kill_o, busy_o, done_o, finished_o, killed_o, timeout_o);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (ch_kill_o !== '0 || busy_o !== 1'b0) n_kill++;
      end
      cmp_cnt++;
      if (n_kill != 0) begin
         err_cnt++; $display("FAIL rst_mid_wait_kill: got %0d bad cycles want 0", n_kill);
      end
   endtask

   task automatic test_random();
      logic [N-1:0]  mask;
      logic [1:0]    mode;
      logic [TW-1:0] tmo;
      int            abort_k;
      for (int t = 0; t < 40; t++) begin
         clr_sched();
         mask    = N'($urandom);
         mode    = 2'($urandom_range(0, 3));
         tmo     = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 40));
         abort_k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 45) : 0;
         for (int ch = 0; ch < N; ch++) begin
            int k;
            k = $urandom_range(1, 40);
            sched[k][ch] = 1'b1;
         end
         for (int j = 0; j < 6; j++) begin
            int k;
            k = $urandom_range(1, 50);
            sched[k] = sched[k] | N'($urandom);
         end
         run_txn($sformatf("rand%0d", t), mask, mode, tmo, abort_k, ($urandom_range(0, 1) == 1));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
